// File: rtl/rover_drive_sequencer.sv
// Purpose : rover drive sequencer; syncs and debounces the line/proximity sensors, runs the follow/avoid/search FSM, PWM-gates the motor drive.
// Latency : raw sensor edge -> filtered value 2+DEBOUNCE_CYC cycles; filtered value -> state/cmd 1 cycle; cmd -> motor_cmd 1 more cycle.
// Backpressure: none; free-running, every output updates each cycle; enable=0 forces IDLE/STOP on the next clock.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   induct[2:0]  : raw inductive sensors {left, centre, right}, asynchronous to clk
//   proxim       : raw proximity sensor, 1 = obstacle, asynchronous to clk
//   enable       : run request (synchronous)
//   duty         : PWM duty; all-ones = always on, 0 = always off
//   motor_cmd    : registered H-bridge drive
//   state_o      : current FSM state encoding
//   obst_count   : completed avoid manoeuvres, saturating at 255
//   fault        : SEARCH timed out; sticky until rst_n
//   busy         : 1 in any state except IDLE
module rover_drive_sequencer #(
  parameter int unsigned DEBOUNCE_CYC  = 4,
  parameter int unsigned OBST_HOLD_CYC = 16,
  parameter int unsigned REV_CYC       = 8,
  parameter int unsigned PIVOT_CYC     = 12,
  parameter int unsigned LOST_CYC      = 32,
  parameter int unsigned PWM_BITS      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          induct,
  input  logic                proxim,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  output logic [3:0]          motor_cmd,
  output logic [2:0]          state_o,
  output logic [7:0]          obst_count,
  output logic                fault,
  output logic                busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FOLLOW  = 3'd1,
    ST_OBST    = 3'd2,
    ST_REVERSE = 3'd3,
    ST_PIVOT   = 3'd4,
    ST_SEARCH  = 3'd5
  } state_e;

  localparam logic [3:0] CMD_STOP  = 4'b0000;
  localparam logic [3:0] CMD_FWD   = 4'b0101;
  localparam logic [3:0] CMD_LEFT  = 4'b1010;
  localparam logic [3:0] CMD_RIGHT = 4'b0110;
  localparam logic [3:0] CMD_REV   = 4'b1001;

  localparam logic TURN_LEFT  = 1'b0;
  localparam logic TURN_RIGHT = 1'b1;

  // One shared state timer is enough: only one state's timer is live at a
  // time and every timer restarts on state entry.
  localparam int unsigned TMR_W = 16;
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0] LOST_LAST   = TMR_W'(LOST_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(OBST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] REV_LAST    = TMR_W'(REV_CYC - 1);
  localparam logic [TMR_W-1:0] PIVOT_LAST  = TMR_W'(PIVOT_CYC - 1);
  localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(4 * LOST_CYC - 1);
  localparam logic [7:0]       DB_LAST     = 8'(DEBOUNCE_CYC - 1);

  // ---------------------------------------------------------------------------
  // Input path: bit order {left, centre, right, proxim}
  // ---------------------------------------------------------------------------
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      filt_q, filt_d;
  logic [3:0][7:0] db_cnt_q, db_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {induct, proxim};
      sync2_q <= sync1_q;
    end
  end

  // A bit's counter runs only while the synchronised value disagrees with the
  // filtered one; the filtered bit flips on the DEBOUNCE_CYC-th disagreeing
  // cycle. Any agreeing cycle (a bounce back) zeroes the count.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    for (int b = 0; b < 4; b++) begin
      if (sync2_q[b] != filt_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          filt_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= '0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  logic [2:0] ind_f;
  logic       prox_f;
  assign ind_f  = filt_q[3:1];
  assign prox_f = filt_q[0];

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             last_turn_q, last_turn_d;
  logic             fault_q, fault_d;
  logic [7:0]       obst_cnt_q, obst_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      cmd_q       <= CMD_STOP;
      last_turn_q <= TURN_LEFT;
      fault_q     <= 1'b0;
      obst_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cmd_q       <= cmd_d;
      last_turn_q <= last_turn_d;
      fault_q     <= fault_d;
      obst_cnt_q  <= obst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    cmd_d       = cmd_q;
    last_turn_d = last_turn_q;
    fault_d     = fault_q;
    obst_cnt_d  = obst_cnt_q;

    if (!enable) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fault_q) state_d = ST_FOLLOW;
        end
        ST_FOLLOW: begin
          // Obstacle wins over steering; the timer here is the lost-line run.
          if (prox_f) begin
            state_d = ST_OBST;
          end else if (ind_f == 3'b000) begin
            if (tmr_q == LOST_LAST) state_d = ST_SEARCH;
            else                    tmr_d   = tmr_q + TMR_ONE;
          end else begin
            tmr_d = '0;
          end
        end
        ST_OBST: begin
          if (!prox_f)                 state_d = ST_FOLLOW;
          else if (tmr_q == HOLD_LAST) state_d = ST_REVERSE;
          else                         tmr_d   = tmr_q + TMR_ONE;
        end
        ST_REVERSE: begin
          if (tmr_q == REV_LAST) state_d = ST_PIVOT;
          else                   tmr_d   = tmr_q + TMR_ONE;
        end
        ST_PIVOT: begin
          // Only a pivot that runs its full length counts as a manoeuvre.
          if (tmr_q == PIVOT_LAST) begin
            state_d = ST_SEARCH;
            if (obst_cnt_q != 8'hFF) obst_cnt_d = obst_cnt_q + 8'd1;
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
        ST_SEARCH: begin
          if (prox_f) begin
            state_d = ST_OBST;
          end else if (ind_f != 3'b000) begin
            state_d = ST_FOLLOW;
          end else if (tmr_q == SEARCH_LAST) begin
            state_d = ST_IDLE;
            fault_d = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != state_q) tmr_d = '0;

    // The command is chosen for the state being entered, so cmd_q always
    // belongs to state_q.
    unique case (state_d)
      ST_FOLLOW: begin
        unique case (ind_f)
          3'b010, 3'b111: cmd_d = CMD_FWD;
          3'b001, 3'b011: begin
            cmd_d       = CMD_LEFT;
            last_turn_d = TURN_LEFT;
          end
          3'b100, 3'b110: begin
            cmd_d       = CMD_RIGHT;
            last_turn_d = TURN_RIGHT;
          end
          default: cmd_d = cmd_q;  // 000 / 101: keep the last heading
        endcase
      end
      ST_REVERSE: cmd_d = CMD_REV;
      ST_PIVOT:   cmd_d = (last_turn_q == TURN_LEFT) ? CMD_RIGHT : CMD_LEFT;
      ST_SEARCH:  cmd_d = (last_turn_q == TURN_LEFT) ? CMD_LEFT  : CMD_RIGHT;
      default:    cmd_d = CMD_STOP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PWM output stage
  // ---------------------------------------------------------------------------
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [3:0]          motor_q, motor_d;
  logic                pwm_on;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    // All-ones duty is treated as full on, otherwise it would miss one slot.
    pwm_on    = (pwm_cnt_q < duty) || (duty == '1);
    motor_d   = pwm_on ? cmd_q : CMD_STOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      motor_q   <= CMD_STOP;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      motor_q   <= motor_d;
    end
  end

  assign motor_cmd  = motor_q;
  assign state_o    = state_q;
  assign obst_count = obst_cnt_q;
  assign fault      = fault_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rover_drive_sequencer.sv
// Purpose : self-checking bench for rover_drive_sequencer against a behavioural model.
// Latency : model predicts every output every cycle; directed literal checks pin key instants.
// Backpressure: n/a.
module tb_rover_drive_sequencer;

  localparam int DB    = 4;
  localparam int HOLD  = 16;
  localparam int REVC  = 8;
  localparam int PIV   = 12;
  localparam int LOST  = 32;

  localparam int S_IDLE = 0, S_FOLLOW = 1, S_OBST = 2, S_REV = 3, S_PIVOT = 4, S_SEARCH = 5;
  localparam logic [3:0] STOP = 4'b0000, FWD = 4'b0101, LEFT = 4'b1010, RIGHT = 4'b0110, REV = 4'b1001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] induct;
  logic       proxim;
  logic       enable;
  logic [3:0] duty;
  logic [3:0] motor_cmd;
  logic [2:0] state_o;
  logic [7:0] obst_count;
  logic       fault;
  logic       busy;

  rover_drive_sequencer #(
    .DEBOUNCE_CYC(DB), .OBST_HOLD_CYC(HOLD), .REV_CYC(REVC),
    .PIVOT_CYC(PIV), .LOST_CYC(LOST), .PWM_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .induct(induct), .proxim(proxim),
    .enable(enable), .duty(duty), .motor_cmd(motor_cmd), .state_o(state_o),
    .obst_count(obst_count), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: history window filter, age-in-state rules, PWM slot
  // ---------------------------------------------------------------------------
  int         m_state, m_age, m_pwm, m_obst;
  logic [3:0] m_cmd, m_motor, m_filt;
  bit         m_turn_right, m_fault;
  logic [3:0] hist[$];  // hist[i] = raw {induct,proxim} seen i clocks ago

  task automatic model_reset();
    m_state = S_IDLE; m_age = 0; m_pwm = 0; m_obst = 0;
    m_cmd = STOP; m_motor = STOP; m_filt = 4'b0000;
    m_turn_right = 1'b0; m_fault = 1'b0;
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(4'b0000);
  endtask

  task automatic model_step();
    logic [2:0] ind;
    logic       prox;
    int         nxt;
    bit         all_diff;
    ind  = m_filt[3:1];
    prox = m_filt[0];

    // motor output reflects the command held before this clock
    if (duty == 4'hF || m_pwm < int'(duty)) m_motor = m_cmd;
    else                                    m_motor = STOP;
    m_pwm = (m_pwm + 1) % 16;

    nxt = m_state;
    if (!enable) nxt = S_IDLE;
    else begin
      case (m_state)
        S_IDLE:   if (!m_fault) nxt = S_FOLLOW;
        S_FOLLOW: if (prox) nxt = S_OBST;
                  else if (ind == 3'b000 && m_age + 1 == LOST) nxt = S_SEARCH;
        S_OBST:   if (!prox) nxt = S_FOLLOW;
                  else if (m_age + 1 == HOLD) nxt = S_REV;
        S_REV:    if (m_age + 1 == REVC) nxt = S_PIVOT;
        S_PIVOT:  if (m_age + 1 == PIV) begin
                    nxt = S_SEARCH;
                    if (m_obst < 255) m_obst++;
                  end
        S_SEARCH: if (prox) nxt = S_OBST;
                  else if (ind != 3'b000) nxt = S_FOLLOW;
                  else if (m_age + 1 == 4 * LOST) begin
                    nxt = S_IDLE;
                    m_fault = 1'b1;
                  end
        default:  nxt = S_IDLE;
      endcase
    end

    if (nxt != m_state || nxt == S_IDLE) m_age = 0;
    else if (m_state == S_FOLLOW)        m_age = (ind == 3'b000) ? m_age + 1 : 0;
    else                                 m_age++;

    case (nxt)
      S_FOLLOW: begin
        if (ind == 3'b010 || ind == 3'b111) m_cmd = FWD;
        else if (ind == 3'b001 || ind == 3'b011) begin m_cmd = LEFT;  m_turn_right = 1'b0; end
        else if (ind == 3'b100 || ind == 3'b110) begin m_cmd = RIGHT; m_turn_right = 1'b1; end
      end
      S_REV:    m_cmd = REV;
      S_PIVOT:  m_cmd = m_turn_right ? LEFT : RIGHT;
      S_SEARCH: m_cmd = m_turn_right ? RIGHT : LEFT;
      default:  m_cmd = STOP;
    endcase
    m_state = nxt;

    // a filtered bit follows the synchroniser output once its last DB values
    // all disagree with it (synchroniser output = raw two clocks back)
    hist.push_front({induct, proxim});
    void'(hist.pop_back());
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++)
        if (hist[2 + j][b] == m_filt[b]) all_diff = 1'b0;
      if (all_diff) m_filt[b] = hist[2][b];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // compare process: every cycle, on the falling edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_motor", 32'(motor_cmd), 32'(STOP));
        check("rst_state", 32'(state_o), 32'(S_IDLE));
        check("rst_fault", 32'(fault), 32'd0);
      end else begin
        check("motor_cmd",  32'(motor_cmd),  32'(m_motor));
        check("state_o",    32'(state_o),    32'(m_state));
        check("obst_count", 32'(obst_count), 32'(m_obst));
        check("fault",      32'(fault),      32'(m_fault));
        check("busy",       32'(busy),       32'(m_state != S_IDLE));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed literal expectations
  // ---------------------------------------------------------------------------
  int cnt;

  initial begin
    rst_n = 1'b0; enable = 1'b1; duty = 4'hF; induct = 3'b010; proxim = 1'b0;
    step(3);
    check("lit_reset_motor", 32'(motor_cmd), 32'h0);
    check("lit_reset_state", 32'(state_o), 32'd0);
    check("lit_reset_obst", 32'(obst_count), 32'd0);
    check("lit_reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // first line acquisition: FWD appears on edge 2+DB+2 = 8
    step(1);
    check("lit_follow_state", 32'(state_o), 32'd1);
    check("lit_follow_busy", 32'(busy), 32'd1);
    step(6);
    check("lit_fwd_edge7", 32'(motor_cmd), 32'h0);
    step(1);
    check("lit_fwd_edge8", 32'(motor_cmd), 32'h5);

    // glitch shorter than the debounce window is ignored
    induct = 3'b001; step(DB - 1);
    induct = 3'b010; step(10);
    check("lit_glitch_fwd", 32'(motor_cmd), 32'h5);

    // steady 001 -> LEFT
    induct = 3'b001; step(20);
    check("lit_left", 32'(motor_cmd), 32'hA);

    // full avoid manoeuvre; t0 = now
    induct = 3'b000; proxim = 1'b1;
    step(8);
    check("lit_obst_state", 32'(state_o), 32'd2);
    check("lit_obst_stop", 32'(motor_cmd), 32'h0);
    step(12); proxim = 1'b0;                      // t0+20
    step(4);                                      // t0+24
    check("lit_rev_state", 32'(state_o), 32'd3);
    check("lit_rev_cmd", 32'(motor_cmd), 32'h9);
    step(7);                                      // t0+31
    check("lit_pivot_state", 32'(state_o), 32'd4);
    step(1);
    check("lit_pivot_cmd", 32'(motor_cmd), 32'h6);
    step(11);                                     // t0+43
    check("lit_search_state", 32'(state_o), 32'd5);
    check("lit_obst_count1", 32'(obst_count), 32'd1);
    step(1);
    check("lit_search_cmd", 32'(motor_cmd), 32'hA);
    induct = 3'b010; step(8);                     // t0+52
    check("lit_refollow_state", 32'(state_o), 32'd1);
    check("lit_refollow_cmd", 32'(motor_cmd), 32'h5);

    // short obstacle: back to FOLLOW, no manoeuvre counted
    step(10);
    proxim = 1'b1; step(10); proxim = 1'b0;
    check("lit_short_obst", 32'(state_o), 32'd2);
    step(8);
    check("lit_short_back", 32'(state_o), 32'd1);
    check("lit_short_cmd", 32'(motor_cmd), 32'h5);
    check("lit_short_count", 32'(obst_count), 32'd1);

    // line lost: SEARCH after 32 cycles, fault after a further 128
    step(5);
    induct = 3'b000;
    step(37);
    check("lit_lost_follow", 32'(state_o), 32'd1);
    step(1);
    check("lit_lost_search", 32'(state_o), 32'd5);
    step(127);
    check("lit_search_last", 32'(state_o), 32'd5);
    step(1);
    check("lit_timeout_idle", 32'(state_o), 32'd0);
    check("lit_timeout_fault", 32'(fault), 32'd1);
    step(1);
    check("lit_timeout_motor", 32'(motor_cmd), 32'h0);

    // fault is sticky through enable toggling
    enable = 1'b0; step(3); enable = 1'b1; induct = 3'b010; step(10);
    check("lit_sticky_state", 32'(state_o), 32'd0);
    check("lit_sticky_fault", 32'(fault), 32'd1);

    // only rst_n clears it, asynchronously
    rst_n = 1'b0; #1;
    check("lit_async_fault", 32'(fault), 32'd0);
    check("lit_async_busy", 32'(busy), 32'd0);
    step(2); duty = 4'd4; rst_n = 1'b1;

    // PWM duty 4/16
    step(20);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (motor_cmd == FWD) cnt++;
    end
    check("lit_pwm_duty4", 32'(cnt), 32'd4);
    duty = 4'd0; step(3);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (motor_cmd != STOP) cnt++;
    end
    check("lit_pwm_duty0", 32'(cnt), 32'd0);

    // RIGHT turn, then obstacle; drop enable mid-PIVOT
    duty = 4'hF; induct = 3'b100; step(20);
    check("lit_right", 32'(motor_cmd), 32'h6);
    induct = 3'b000; proxim = 1'b1;
    step(20); proxim = 1'b0;
    step(12);                                     // t0+32
    check("lit_pivot2_state", 32'(state_o), 32'd4);
    check("lit_pivot2_cmd", 32'(motor_cmd), 32'hA);
    step(3); enable = 1'b0;
    step(1);
    check("lit_drop_idle", 32'(state_o), 32'd0);
    step(1);
    check("lit_drop_motor", 32'(motor_cmd), 32'h0);
    check("lit_drop_count", 32'(obst_count), 32'd0);
    enable = 1'b1; step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rover_drive_sequencer.md
Name: rover_drive_sequencer

Overview:
- Clocked controller that sequences the rover drive motors from the three inductive line sensors and the proximity sensor.
- Synchronises and debounces the raw sensor inputs, then runs a line-follow / obstacle-avoid / line-search state machine.
- Gates the resulting 4-bit motor command with a PWM duty stage.
- Sits between the sensor pins and the H-bridge motor inputs.

Parameters:
- DEBOUNCE_CYC, 4: consecutive stable cycles required before a filtered sensor value updates (range 1-255).
- OBST_HOLD_CYC, 16: cycles proximity must stay asserted in OBST before the avoid manoeuvre starts.
- REV_CYC, 8: cycles spent reversing.
- PIVOT_CYC, 12: cycles spent pivoting away from the obstacle.
- LOST_CYC, 32: cycles of induct==000 in FOLLOW before entering SEARCH; SEARCH times out after 4*LOST_CYC.
- PWM_BITS, 4: width of the PWM counter and of duty.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- induct  in  3  raw inductive sensors {left, centre, right}; async to clk
- proxim  in  1  raw proximity sensor, 1 = obstacle; async to clk
- enable  in  1  run request, synchronous to clk
- duty  in  PWM_BITS  motor duty setting
- motor_cmd  out  4  H-bridge drive, registered
- state_o  out  3  current FSM state encoding
- obst_count  out  8  number of completed avoid manoeuvres, saturating
- fault  out  1  SEARCH timed out; sticky
- busy  out  1  1 in any state except IDLE

Behaviour:
- Reset values: motor_cmd=0000, state=IDLE, obst_count=0, fault=0, busy=0, filtered sensors=0, last_turn=LEFT, PWM counter=0, all timers=0.
- Command codes:
  - STOP=0000
  - FWD=0101
  - LEFT=1010
  - RIGHT=0110
  - REV=1001
- Input path:
  - 2-FF synchroniser on induct[2:0] and proxim.
  - Each filtered bit takes the synchronised value only after it differs from the current filtered value for DEBOUNCE_CYC consecutive cycles.
  - Any bounce restarts that bit's count.
  - Total latency from raw edge to filtered edge: 2+DEBOUNCE_CYC cycles.
- State encodings: IDLE=0, FOLLOW=1, OBST=2, REVERSE=3, PIVOT=4, SEARCH=5.
- IDLE:
  - cmd=STOP.
  - enable=1 and fault=0 -> FOLLOW.
- FOLLOW, steering from filtered induct:
  - 010 or 111 -> FWD.
  - 001 or 011 -> LEFT; last_turn<=LEFT.
  - 100 or 110 -> RIGHT; last_turn<=RIGHT.
  - 101 -> hold previous cmd.
  - 000 -> hold previous cmd and increment lost timer; the timer clears on any non-000 value. After LOST_CYC consecutive 000 cycles -> SEARCH.
  - Filtered proxim=1 -> OBST; this takes priority over steering in the same cycle.
- OBST:
  - cmd=STOP; hold timer counts while proxim=1.
  - proxim drops before OBST_HOLD_CYC -> FOLLOW.
  - Timer reaches OBST_HOLD_CYC -> REVERSE.
- REVERSE: cmd=REV for REV_CYC cycles -> PIVOT. Proxim is ignored.
- PIVOT:
  - cmd is the opposite of last_turn, for PIVOT_CYC cycles.
  - On exit: obst_count += 1 (saturates at 255) -> SEARCH.
- SEARCH:
  - cmd is the turn toward last_turn.
  - Any filtered induct != 000 -> FOLLOW.
  - 4*LOST_CYC cycles without a line -> IDLE with fault<=1.
  - Proxim=1 in SEARCH -> OBST.
- enable=0 in any state -> IDLE on the next clock; cmd=STOP; all timers clear. enable has priority over every other transition.
- fault clears only on rst_n.
- A timer always restarts at 0 on entry to its state.
- PWM:
  - Free-running PWM_BITS counter.
  - motor_cmd <= cmd when (pwm_cnt < duty) or (duty == all-ones); otherwise STOP.
  - duty=0 -> motor_cmd permanently STOP.
  - motor_cmd is registered: it lags the state/cmd update by 1 cycle.
- Reset asserted mid-manoeuvre: all outputs return to reset values immediately (asynchronous); the FSM restarts in IDLE.

Test Plan:
- Reset, enable=1, duty=all-ones, induct=010 held -> state FOLLOW; motor_cmd=0101 from cycle 2+DEBOUNCE_CYC+2 onward; busy=1.
- induct=001 glitch of DEBOUNCE_CYC-1 cycles during FWD -> motor_cmd stays 0101. Held longer -> 1010 and last_turn=LEFT.
- proxim=1 for 20 cycles, defaults -> OBST, STOP; REVERSE 1001 for 8 cycles; PIVOT 0110 for 12 cycles; SEARCH 1010; obst_count=1. Then induct=010 -> FOLLOW.
- proxim=1 for 10 cycles then 0 -> OBST then back to FOLLOW; obst_count unchanged; no REV observed.
- induct=000 for 32+128 cycles -> SEARCH, then IDLE with fault=1 and motor_cmd=0000. Toggling enable does not leave IDLE; only rst_n clears fault.
- duty=4, PWM_BITS=4, FWD -> motor_cmd=0101 for 4 of every 16 cycles. duty=0 -> always 0000. enable drop mid-PIVOT -> IDLE and 0000 within 2 cycles.
